seg7_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_decode.sv | 35 +++
 rtl/seg7_scan_driver.sv | 142 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared glyph constants and width helper for the 7-segment scan driver.
// Glyph bit order is A..G from bit 6 down to bit 0, active low.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] GLYPH_0 = 7'b0000001;
    localparam logic [6:0] GLYPH_1 = 7'b1001111;
    localparam logic [6:0] GLYPH_2 = 7'b0010010;
    localparam logic [6:0] GLYPH_3 = 7'b0000110;
    localparam logic [6:0] GLYPH_4 = 7'b1001100;
    localparam logic [6:0] GLYPH_5 = 7'b0100100;
    localparam logic [6:0] GLYPH_6 = 7'b0100000;
    localparam logic [6:0] GLYPH_7 = 7'b0001111;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0000100;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b1100000;
    localparam logic [6:0] GLYPH_C = 7'b0110001;
    localparam logic [6:0] GLYPH_D = 7'b1000010;
    localparam logic [6:0] GLYPH_E = 7'b0110000;
    localparam logic [6:0] GLYPH_F = 7'b0111000;

    // Bits needed to hold 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to segment decoder with blanking and optional hex glyphs.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_mode,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (code)
                4'h0: seg = GLYPH_0;
                4'h1: seg = GLYPH_1;
                4'h2: seg = GLYPH_2;
                4'h3: seg = GLYPH_3;
                4'h4: seg = GLYPH_4;
                4'h5: seg = GLYPH_5;
                4'h6: seg = GLYPH_6;
                4'h7: seg = GLYPH_7;
                4'h8: seg = GLYPH_8;
                4'h9: seg = GLYPH_9;
                4'hA: seg = hex_mode ? GLYPH_A : SEG_BLANK;
                4'hB: seg = hex_mode ? GLYPH_B : SEG_BLANK;
                4'hC: seg = hex_mode ? GLYPH_C : SEG_BLANK;
                4'hD: seg = hex_mode ? GLYPH_D : SEG_BLANK;
                4'hE: seg = hex_mode ? GLYPH_E : SEG_BLANK;
                default: seg = hex_mode ? GLYPH_F : SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with a double-buffered
// digit register that only swaps at frame boundaries while scanning.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2,
    parameter int HEX_MODE     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int IDX_W = clog2(NUM_DIGITS);
    localparam int PRE_W = clog2(REFRESH_DIV);
    localparam logic [NUM_DIGITS-1:0] AN_ONE = 1;

    logic [PRE_W-1:0]        presc_reg, presc_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [4*NUM_DIGITS-1:0] act_digits_reg, act_digits_next;
    logic [NUM_DIGITS-1:0]   act_dp_reg, act_dp_next;
    logic [4*NUM_DIGITS-1:0] pend_digits_reg, pend_digits_next;
    logic [NUM_DIGITS-1:0]   pend_dp_reg, pend_dp_next;
    logic                    pend_flag_reg, pend_flag_next;
    logic [6:0]              seg_reg, seg_next;
    logic                    dp_reg, dp_next;
    logic [NUM_DIGITS-1:0]   an_reg, an_next;

    logic                    tick, frame_end;
    logic [3:0]              code_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic [3:0]              cur_code;
    logic                    cur_blank;
    logic [6:0]              dec_seg;

    // Digit i blanks only when it and every more-significant digit are zero.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign code_arr[gi] = act_digits_reg[4*gi +: 4];
        if (gi == 0) begin : g_lsd
            assign blank_vec[gi] = 1'b0;
        end else begin : g_upper
            assign blank_vec[gi] = lz_blank && (act_digits_reg[4*NUM_DIGITS-1:4*gi] == '0);
        end
    end

    assign cur_code  = code_arr[idx_reg];
    assign cur_blank = blank_vec[idx_reg];

    seg7_decode u_decode (
        .code     (cur_code),
        .hex_mode (HEX_MODE != 0),
        .blank    (cur_blank),
        .seg      (dec_seg)
    );

    always_comb begin
        tick             = en && (presc_reg == PRE_W'(REFRESH_DIV - 1));
        frame_end        = tick && (idx_reg == IDX_W'(NUM_DIGITS - 1));
        presc_next       = presc_reg;
        idx_next         = idx_reg;
        act_digits_next  = act_digits_reg;
        act_dp_next      = act_dp_reg;
        pend_digits_next = pend_digits_reg;
        pend_dp_next     = pend_dp_reg;
        pend_flag_next   = pend_flag_reg;

        if (en) begin
            presc_next = tick ? '0 : presc_reg + PRE_W'(1);
            if (tick) begin
                idx_next = frame_end ? '0 : idx_reg + IDX_W'(1);
            end
        end

        // A load that lands on the frame boundary bypasses the pending stage.
        if (!en || frame_end) begin
            if (load) begin
                act_digits_next = digits_in;
                act_dp_next     = dp_in;
                pend_flag_next  = 1'b0;
            end else if (frame_end && pend_flag_reg) begin
                act_digits_next = pend_digits_reg;
                act_dp_next     = pend_dp_reg;
                pend_flag_next  = 1'b0;
            end
        end else if (load) begin
            pend_digits_next = digits_in;
            pend_dp_next     = dp_in;
            pend_flag_next   = 1'b1;
        end

        seg_next = SEG_BLANK;
        dp_next  = 1'b1;
        an_next  = '1;
        if (en) begin
            seg_next = dec_seg;
            dp_next  = ~act_dp_reg[idx_reg];
            if (presc_reg >= PRE_W'(BLANK_CYCLES)) begin
                an_next = ~(AN_ONE << idx_reg);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg       <= '0;
            idx_reg         <= '0;
            act_digits_reg  <= '0;
            act_dp_reg      <= '0;
            pend_digits_reg <= '0;
            pend_dp_reg     <= '0;
            pend_flag_reg   <= 1'b0;
            seg_reg         <= SEG_BLANK;
            dp_reg          <= 1'b1;
            an_reg          <= '1;
        end else begin
            presc_reg       <= presc_next;
            idx_reg         <= idx_next;
            act_digits_reg  <= act_digits_next;
            act_dp_reg      <= act_dp_next;
            pend_digits_reg <= pend_digits_next;
            pend_dp_reg     <= pend_dp_next;
            pend_flag_reg   <= pend_flag_next;
            seg_reg         <= seg_next;
            dp_reg          <= dp_next;
            an_reg          <= an_next;
        end
    end

    assign seg = seg_reg;
    assign dp  = dp_reg;
    assign an  = an_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: a frame-level model pushes the expected display each cycle,
// a negedge monitor compares both a hex-mode and a decimal-mode instance.
module tb_seg7_scan_driver;

    localparam int NUMD    = 4;
    localparam int REFRESH = 4;
    localparam int BLANK   = 1;
    localparam int FRAME   = NUMD * REFRESH;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg_h;
        logic [6:0] seg_d;
        logic       dp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic        lz_blank = 1'b0;
    logic [6:0]  seg_h, seg_d;
    logic        dp_h, dp_d;
    logic [3:0]  an_h, an_d;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    exp_t sb[$];

    seg7_scan_driver #(
        .NUM_DIGITS(NUMD), .REFRESH_DIV(REFRESH), .BLANK_CYCLES(BLANK), .HEX_MODE(1)
    ) dut_hex (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in),
        .dp_in(dp_in), .lz_blank(lz_blank), .seg(seg_h), .dp(dp_h), .an(an_h)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(NUMD), .REFRESH_DIV(REFRESH), .BLANK_CYCLES(BLANK), .HEX_MODE(0)
    ) dut_dec (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in),
        .dp_in(dp_in), .lz_blank(lz_blank), .seg(seg_d), .dp(dp_d), .an(an_d)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] code, input bit hex);
        case (code)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return hex ? 7'b0001000 : 7'b1111111;
            4'hB: return hex ? 7'b1100000 : 7'b1111111;
            4'hC: return hex ? 7'b0110001 : 7'b1111111;
            4'hD: return hex ? 7'b1000010 : 7'b1111111;
            4'hE: return hex ? 7'b0110000 : 7'b1111111;
            default: return hex ? 7'b0111000 : 7'b1111111;
        endcase
    endfunction

    // Reference model: enabled-cycle count gives slot and phase arithmetically.
    int          ecount = 0;
    logic [15:0] disp_digits = '0, pend_digits = '0;
    logic [3:0]  disp_dp = '0, pend_dp = '0;
    bit          pend_valid = 0;
    int          m_ph, m_d;
    bit          m_blank, m_fend;
    exp_t        m_e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecount = 0;
            disp_digits = '0; disp_dp = '0;
            pend_digits = '0; pend_dp = '0; pend_valid = 0;
            sb.delete();
        end else begin
            m_ph = ecount % REFRESH;
            m_d  = (ecount / REFRESH) % NUMD;
            if (en) begin
                m_e.an    = (m_ph >= BLANK) ? ~(4'b0001 << m_d) : 4'b1111;
                m_blank   = lz_blank && (m_d > 0) && ((disp_digits >> (4 * m_d)) == 16'd0);
                m_e.seg_h = m_blank ? 7'b1111111 : glyph(disp_digits[4*m_d +: 4], 1);
                m_e.seg_d = m_blank ? 7'b1111111 : glyph(disp_digits[4*m_d +: 4], 0);
                m_e.dp    = ~disp_dp[m_d];
            end else begin
                m_e = '{an: 4'b1111, seg_h: 7'b1111111, seg_d: 7'b1111111, dp: 1'b1};
            end
            sb.push_back(m_e);

            m_fend = en && (ecount % FRAME == FRAME - 1);
            if (!en && load) begin
                disp_digits = digits_in; disp_dp = dp_in; pend_valid = 0;
            end else if (m_fend) begin
                if (load) begin
                    disp_digits = digits_in; disp_dp = dp_in; pend_valid = 0;
                end else if (pend_valid) begin
                    disp_digits = pend_digits; disp_dp = pend_dp; pend_valid = 0;
                end
            end else if (load) begin
                pend_digits = digits_in; pend_dp = dp_in; pend_valid = 1;
            end
            if (en) ecount = ecount + 1;
        end
    end

    exp_t mon_e;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks = checks + 1;
            if (an_h == mon_e.an && an_d == mon_e.an && seg_h == mon_e.seg_h &&
                seg_d == mon_e.seg_d && dp_h == mon_e.dp && dp_d == mon_e.dp &&
                $countones(~an_h) <= 1) begin
                passes = passes + 1;
            end else begin
                $display("FAIL scan cyc=%0d got an=%b/%b seg_h=%b seg_d=%b dp=%b/%b want an=%b seg_h=%b seg_d=%b dp=%b",
                         cyc, an_h, an_d, seg_h, seg_d, dp_h, dp_d,
                         mon_e.an, mon_e.seg_h, mon_e.seg_d, mon_e.dp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        digits_in = d;
        dp_in = p;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    // Advance until the next edge processes the given cycle of a frame.
    task automatic wait_phase(input int target);
        int n;
        n = 0;
        while ((ecount % FRAME) != target && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            checks = checks + 1;
            $display("FAIL wait_phase timeout target=%0d got=%0d", target, ecount % FRAME);
        end
    endtask

    task automatic check_reset(input string name);
        checks = checks + 1;
        if (an_h == 4'b1111 && an_d == 4'b1111 && seg_h == 7'b1111111 &&
            seg_d == 7'b1111111 && dp_h == 1'b1 && dp_d == 1'b1) begin
            passes = passes + 1;
        end else begin
            $display("FAIL %s got an=%b seg=%b dp=%b want an=1111 seg=1111111 dp=1",
                     name, an_h, seg_h, dp_h);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset_hold");
        rst_n = 1'b1;
        en = 1'b1;

        // anode rotation from reset
        run(32);

        // leading-zero blanking on and off
        wait_phase(0);
        lz_blank = 1'b1;
        do_load(16'h0042, 4'b0010);
        run(32);
        lz_blank = 1'b0;
        run(16);

        // mid-frame load waits for the frame boundary
        wait_phase(0);
        do_load(16'h5678, 4'b0001);
        run(16);
        wait_phase(6);
        do_load(16'h1234, 4'b1000);
        run(32);

        // load on frame_end, then a second load in the following frame
        wait_phase(15);
        do_load(16'h9081, 4'b0100);
        wait_phase(5);
        do_load(16'h3574, 4'b0011);
        run(48);

        // hex glyphs versus blanked codes
        wait_phase(0);
        do_load(16'hBBBB, 4'b0000);
        run(32);
        wait_phase(0);
        lz_blank = 1'b1;
        do_load(16'h0CAF, 4'b0101);
        run(32);
        lz_blank = 1'b0;

        // disable mid-slot with a direct load while stopped
        wait_phase(6);
        en = 1'b0;
        run(3);
        do_load(16'h9876, 4'b1001);
        run(6);
        en = 1'b1;
        run(20);

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            en = ($urandom_range(0, 4) != 0);
            lz_blank = $urandom_range(0, 1);
            if ($urandom_range(0, 2) == 0) begin
                do_load(16'($urandom), 4'($urandom));
            end else begin
                run($urandom_range(1, 12));
            end
        end
        en = 1'b1;
        run(16);

        // asynchronous reset mid-slot discards a pending load
        wait_phase(3);
        do_load(16'h7777, 4'b1111);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_reset");
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset_held");
        rst_n = 1'b1;
        run(40);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
